// File: rtl/pcla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package pcla_pkg;

    // Bits per carry-lookahead group.
    localparam int unsigned GROUP_W = 4;

    // Generate/propagate pair for one bit or one group.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum, group generate/propagate and carry-out.
module cla_group4
    import pcla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               g,
    output logic               p,
    output logic               co
);

    gp_t [GROUP_W-1:0]  bit_gp;
    logic [GROUP_W-1:0] c;

    // Per-bit generate/propagate, then every internal carry directly from ci.
    always_comb begin
        for (int i = 0; i < GROUP_W; i++) begin
            bit_gp[i].g = a[i] & b[i];
            bit_gp[i].p = a[i] ^ b[i];
        end
        c[0] = ci;
        c[1] = bit_gp[0].g | (bit_gp[0].p & ci);
        c[2] = bit_gp[1].g | (bit_gp[1].p & bit_gp[0].g)
             | (bit_gp[1].p & bit_gp[0].p & ci);
        c[3] = bit_gp[2].g | (bit_gp[2].p & bit_gp[1].g)
             | (bit_gp[2].p & bit_gp[1].p & bit_gp[0].g)
             | (bit_gp[2].p & bit_gp[1].p & bit_gp[0].p & ci);
        g    = bit_gp[3].g | (bit_gp[3].p & bit_gp[2].g)
             | (bit_gp[3].p & bit_gp[2].p & bit_gp[1].g)
             | (bit_gp[3].p & bit_gp[2].p & bit_gp[1].p & bit_gp[0].g);
        p    = bit_gp[3].p & bit_gp[2].p & bit_gp[1].p & bit_gp[0].p;
        co   = g | (p & ci);
        for (int i = 0; i < GROUP_W; i++) begin
            s[i] = bit_gp[i].p ^ c[i];
        end
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// The carry chain across 4-bit groups is registered every (WIDTH/4)/STAGES groups.
// Optional macro PCLA_OVERFLOW_EN adds the signed-overflow output ovf.
module pipelined_cla_adder
    import pcla_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PCLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NG   = WIDTH / GROUP_W;
    localparam int unsigned GPS  = NG / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic en;

    // Stage registers; b_q holds the already-inverted operand in subtract mode.
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];

    // Per-stage operands seen by that stage's groups, and its next-state values.
    logic [STAGES-1:0][WIDTH-1:0] src_a;
    logic [STAGES-1:0][WIDTH-1:0] src_b;
    logic [STAGES-1:0]            src_c;
    logic [STAGES-1:0]            src_v;
    logic [STAGES-1:0][WIDTH-1:0] s_d;
    logic [STAGES-1:0]            c_d;

    logic [GROUP_W-1:0] grp_s  [NG];
    logic               grp_ci [NG];
    logic               grp_g  [NG];
    logic               grp_p  [NG];
    logic               grp_co [NG];

    assign en       = !v_q[LAST] || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign src_a[k] = a;
            assign src_b[k] = b ^ {WIDTH{sub}};
            assign src_c[k] = cin;
            assign src_v[k] = in_valid;
        end else begin : g_next
            assign src_a[k] = a_q[k-1];
            assign src_b[k] = b_q[k-1];
            assign src_c[k] = c_q[k-1];
            assign src_v[k] = v_q[k-1];
        end

        assign c_d[k] = grp_co[(k+1)*GPS-1];

        // Sum bits: earlier groups pass through, this stage's groups are fresh, later ones zero.
        for (genvar g = 0; g < NG; g++) begin : g_sum
            if (g / GPS == k) begin : g_new
                assign s_d[k][g*GROUP_W +: GROUP_W] = grp_s[g];
            end else if (g / GPS < k) begin : g_old
                assign s_d[k][g*GROUP_W +: GROUP_W] = s_q[k-1][g*GROUP_W +: GROUP_W];
            end else begin : g_none
                assign s_d[k][g*GROUP_W +: GROUP_W] = '0;
            end
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        localparam int unsigned K = g / GPS;
        if (g % GPS == 0) begin : g_cin_reg
            assign grp_ci[g] = src_c[K];
        end else begin : g_cin_chain
            assign grp_ci[g] = grp_g[g-1] | (grp_p[g-1] & grp_ci[g-1]);
        end

        cla_group4 u_grp (
            .a  (src_a[K][g*GROUP_W +: GROUP_W]),
            .b  (src_b[K][g*GROUP_W +: GROUP_W]),
            .ci (grp_ci[g]),
            .s  (grp_s[g]),
            .g  (grp_g[g]),
            .p  (grp_p[g]),
            .co (grp_co[g])
        );
    end

    // Advance every stage together on en; data only loads for valid entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= src_v[k];
                if (src_v[k]) begin
                    a_q[k] <= src_a[k];
                    b_q[k] <= src_b[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];

`ifdef PCLA_OVERFLOW_EN
    // Carry into the MSB is recovered as a^b^s at that bit.
    assign ovf = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ s_q[LAST][WIDTH-1] ^ c_q[LAST];
`endif

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter STAGES, default 2: register stages; (WIDTH/4) SHALL be divisible by STAGES.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 sub  input  1  subtract mode; B is bitwise inverted before the add.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry-out of MSB.

Function
REQ-015 The result SHALL be {cout,sum} = a + (b XOR {WIDTH{sub}}) + cin, modulo 2^(WIDTH+1); a-b requires sub=1, cin=1.
REQ-016 The datapath SHALL be split into WIDTH/4 4-bit carry-lookahead groups; the ripple between groups SHALL be registered after every (WIDTH/4)/STAGES groups.
REQ-017 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, absent backpressure.
REQ-018 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-019 Advance enable SHALL be en = !out_valid | out_ready; all stage registers, including valid bits, update only when en=1.
REQ-020 in_ready SHALL equal en (combinational from out_valid/out_ready only, never from in_valid).
REQ-021 While out_valid=1 and out_ready=0, sum, cout and out_valid SHALL hold stable.
REQ-022 Bubbles (in_valid=0 when accepted) SHALL propagate as invalid stages; the pipeline need not be full to drain.
REQ-023 Operands SHALL be captured only on in_valid & in_ready; a and b are don't-care otherwise.

Reset
REQ-024 When rst_n=0 at a clock edge, all stage valid bits SHALL clear; out_valid=0, sum=0, cout=0 in the following cycle.
REQ-025 Reset mid-operation SHALL discard every in-flight result; none SHALL appear after reset deasserts.
REQ-026 in_ready SHALL be 1 in the first cycle after reset (pipeline empty).

Configuration
REQ-027 Macro PCLA_OVERFLOW_EN defined: output ovf (1 bit) SHALL exist, aligned with sum, equal to signed overflow (carry into MSB XOR cout), held under backpressure, reset to 0.
REQ-028 Macro PCLA_OVERFLOW_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package pcla_pkg SHALL hold constant GROUP_W=4 and the generate/propagate group struct type.
REQ-030 One sub-module, cla_group4, SHALL implement a combinational 4-bit lookahead group (a, b, ci -> s, group G, group P, co), instantiated WIDTH/4 times.

Verification (WIDTH=16, STAGES=2, PCLA_OVERFLOW_EN defined)
REQ-031 a=5, b=6, cin=1, sub=0, out_ready=1 -> out_valid exactly 2 cycles later, sum=0x000C, cout=0, ovf=0.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-033 sub=1, cin=1, a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, ovf=0; a=0x0005, b=0x0003 -> sum=0x0002, cout=1.
REQ-034 Back-to-back stream of 4 ops with out_ready held 0 for 3 cycles after first out_valid -> in_ready=0 during stall, outputs stable, all 4 results delivered in order, none lost or duplicated.
REQ-035 Two ops in flight, rst_n=0 for 1 cycle -> out_valid=0, sum=0 next cycle; no stale result appears afterwards; in_ready=1.
REQ-036 Random 10,000 ops with random in_valid/out_ready and random sub/cin -> every result matches the REQ-015 model, in order.
